// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO peripheral: register map and flag bit positions.
package mmio_pkg;

    // Byte addresses of the mapped registers (bits [1:0] are never decoded)
    localparam logic [31:0] ADDR_TH     = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL     = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON   = 32'h4000_0008;
    localparam logic [31:0] ADDR_LED    = 32'h4000_000C;
    localparam logic [31:0] ADDR_SWITCH = 32'h4000_0010;
    localparam logic [31:0] ADDR_DIGI   = 32'h4000_0014;
    localparam logic [31:0] ADDR_TXD    = 32'h4000_0018;
    localparam logic [31:0] ADDR_RXD    = 32'h4000_001C;
    localparam logic [31:0] ADDR_UCON   = 32'h4000_0020;

    // TCON bit positions
    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

    // UCON bit positions
    localparam int UCON_TX_BUSY  = 0;
    localparam int UCON_TX_DROP  = 1;
    localparam int UCON_RX_VALID = 2;
    localparam int UCON_RX_OVR   = 3;

endpackage

// File: rtl/mmio_timer.sv
// Reloading 32-bit up-counter with sticky interrupt status.
module mmio_timer
    import mmio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wr_th,
    input  logic        i_wr_tl,
    input  logic        i_wr_tcon,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_th,
    output logic [31:0] o_tl,
    output logic [2:0]  o_tcon,
    output logic        o_interrupt
);

    logic [31:0] r_th;
    logic [31:0] r_tl;
    logic [2:0]  r_tcon;
    logic        w_overflow;
    logic        w_set_is;

    // Overflow is judged on the current count, so it still fires when the CPU
    // overwrites TL in the same cycle (the write wins the TL value only).
    assign w_overflow = r_tcon[TCON_EN] && (r_tl == 32'hFFFF_FFFF);
    assign w_set_is   = w_overflow && r_tcon[TCON_IE];

    // Reload register: CPU writes only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_th <= '0;
        else if (i_wr_th) r_th <= i_wdata;
    end

    // Counter: CPU write beats reload, reload beats increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                r_tl <= '0;
        else if (i_wr_tl)          r_tl <= i_wdata;
        else if (w_overflow)       r_tl <= r_th;
        else if (r_tcon[TCON_EN])  r_tl <= r_tl + 32'd1;
    end

    // Control/status: a concurrent overflow keeps the status bit set over a CPU write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tcon <= '0;
        end else if (i_wr_tcon) begin
            r_tcon[TCON_EN] <= i_wdata[TCON_EN];
            r_tcon[TCON_IE] <= i_wdata[TCON_IE];
            r_tcon[TCON_IS] <= i_wdata[TCON_IS] | w_set_is;
        end else if (w_set_is) begin
            r_tcon[TCON_IS] <= 1'b1;
        end
    end

    assign o_th        = r_th;
    assign o_tl        = r_tl;
    assign o_tcon      = r_tcon;
    assign o_interrupt = r_tcon[TCON_IS] & r_tcon[TCON_IE];

endmodule

// File: rtl/mmio_peripheral.sv
// Memory-mapped peripheral block: address decode, GPIO, UART glue and timer.
module mmio_peripheral
    import mmio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] iMemAddr,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic [31:0] iMemWriteData,
    output logic [31:0] oMemReadData,
    output logic        oInterrupt,
    output logic [7:0]  oLed,
    input  logic [7:0]  iSwitch,
    output logic [11:0] oDigi,
    output logic [7:0]  oTxData,
    output logic        oTxStart,
    input  logic        iTxBusy,
    input  logic [7:0]  iRxData,
    input  logic        iRxValid
);

    logic [29:0] w_word;
    logic        w_addr_lo_unused;
    logic [31:0] w_th;
    logic [31:0] w_tl;
    logic [2:0]  w_tcon;
    logic [3:0]  w_ucon;
    logic        w_tx_busy;
    logic        w_wr_txd;
    logic        w_wr_ucon;
    logic        w_tx_accept;
    logic        w_tx_reject;
    logic        w_rd_rxd;

    logic [7:0]  r_led;
    logic [11:0] r_digi;
    logic [7:0]  r_rxd;
    logic [7:0]  r_tx_data;
    logic        r_tx_start;
    logic        r_tx_inflight;
    logic        r_tx_busy_d;
    logic        r_tx_drop;
    logic        r_rx_valid;
    logic        r_rx_ovr;

    // Word address; the byte offset is deliberately ignored
    assign w_word           = iMemAddr[31:2];
    assign w_addr_lo_unused = ^iMemAddr[1:0];

    // TX handshake: a TXD write is accepted only when neither the UART (iTxBusy)
    // nor our own in-flight flag is busy; acceptance raises oTxStart for exactly
    // one cycle and holds the in-flight flag until iTxBusy is seen to fall.
    // Anything written while busy is discarded and recorded in the sticky drop flag.
    assign w_tx_busy   = r_tx_inflight | iTxBusy;
    assign w_wr_txd    = iMemWrite && (w_word == ADDR_TXD[31:2]);
    assign w_wr_ucon   = iMemWrite && (w_word == ADDR_UCON[31:2]);
    assign w_tx_accept = w_wr_txd && !w_tx_busy;
    assign w_tx_reject = w_wr_txd && w_tx_busy;
    assign w_rd_rxd    = iMemRead && (w_word == ADDR_RXD[31:2]);

    always_comb begin
        w_ucon = '0;
        w_ucon[UCON_TX_BUSY]  = w_tx_busy;
        w_ucon[UCON_TX_DROP]  = r_tx_drop;
        w_ucon[UCON_RX_VALID] = r_rx_valid;
        w_ucon[UCON_RX_OVR]   = r_rx_ovr;
    end

    mmio_timer u_timer (
        .clk         (clk),
        .reset       (reset),
        .i_wr_th     (iMemWrite && (w_word == ADDR_TH[31:2])),
        .i_wr_tl     (iMemWrite && (w_word == ADDR_TL[31:2])),
        .i_wr_tcon   (iMemWrite && (w_word == ADDR_TCON[31:2])),
        .i_wdata     (iMemWriteData),
        .o_th        (w_th),
        .o_tl        (w_tl),
        .o_tcon      (w_tcon),
        .o_interrupt (oInterrupt)
    );

    // GPIO output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_led  <= '0;
            r_digi <= '0;
        end else if (iMemWrite) begin
            if (w_word == ADDR_LED[31:2])  r_led  <= iMemWriteData[7:0];
            if (w_word == ADDR_DIGI[31:2]) r_digi <= iMemWriteData[11:0];
        end
    end

    // UART transmit side: data latch, start pulse, in-flight tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_data     <= '0;
            r_tx_start    <= 1'b0;
            r_tx_inflight <= 1'b0;
            r_tx_busy_d   <= 1'b0;
        end else begin
            r_tx_busy_d <= iTxBusy;
            r_tx_start  <= w_tx_accept;
            if (w_tx_accept) begin
                r_tx_data     <= iMemWriteData[7:0];
                r_tx_inflight <= 1'b1;
            end else if (r_tx_busy_d && !iTxBusy) begin
                r_tx_inflight <= 1'b0;
            end
        end
    end

    // UART receive side: capture, valid flag, read-to-clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rxd      <= '0;
            r_rx_valid <= 1'b0;
        end else if (iRxValid) begin
            r_rxd      <= iRxData;
            r_rx_valid <= 1'b1;
        end else if (w_rd_rxd) begin
            r_rx_valid <= 1'b0;
        end
    end

    // Sticky error flags: a new event in the same cycle as a UCON write stays set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_drop <= 1'b0;
            r_rx_ovr  <= 1'b0;
        end else begin
            if (w_tx_reject)                r_tx_drop <= 1'b1;
            else if (w_wr_ucon)             r_tx_drop <= 1'b0;
            if (iRxValid && r_rx_valid)     r_rx_ovr  <= 1'b1;
            else if (w_wr_ucon)             r_rx_ovr  <= 1'b0;
        end
    end

    // Zero-latency read mux; write-only and unmapped addresses read zero
    always_comb begin
        oMemReadData = '0;
        case (w_word)
            ADDR_TH[31:2]:     oMemReadData = w_th;
            ADDR_TL[31:2]:     oMemReadData = w_tl;
            ADDR_TCON[31:2]:   oMemReadData = {29'd0, w_tcon};
            ADDR_LED[31:2]:    oMemReadData = {24'd0, r_led};
            ADDR_SWITCH[31:2]: oMemReadData = {24'd0, iSwitch};
            ADDR_DIGI[31:2]:   oMemReadData = {20'd0, r_digi};
            ADDR_RXD[31:2]:    oMemReadData = {24'd0, r_rxd};
            ADDR_UCON[31:2]:   oMemReadData = {28'd0, w_ucon};
            default:           oMemReadData = '0;
        endcase
    end

    assign oLed     = r_led;
    assign oDigi    = r_digi;
    assign oTxData  = r_tx_data;
    assign oTxStart = r_tx_start;

endmodule

// File: tb/tb_mmio_peripheral.sv
// Directed testbench for mmio_peripheral: register table plus timer/UART/reset sequences.
module tb_mmio_peripheral;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_SW   = 32'h4000_0010;
    localparam logic [31:0] A_DIGI = 32'h4000_0014;
    localparam logic [31:0] A_TXD  = 32'h4000_0018;
    localparam logic [31:0] A_RXD  = 32'h4000_001C;
    localparam logic [31:0] A_UCON = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] iMemAddr = '0;
    logic        iMemRead = 1'b0;
    logic        iMemWrite = 1'b0;
    logic [31:0] iMemWriteData = '0;
    logic [31:0] oMemReadData;
    logic        oInterrupt;
    logic [7:0]  oLed;
    logic [7:0]  iSwitch = '0;
    logic [11:0] oDigi;
    logic [7:0]  oTxData;
    logic        oTxStart;
    logic        iTxBusy = 1'b0;
    logic [7:0]  iRxData = '0;
    logic        iRxValid = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int tx_pulses = 0;
    int p0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[12];

    mmio_peripheral dut (
        .clk           (clk),
        .reset         (reset),
        .iMemAddr      (iMemAddr),
        .iMemRead      (iMemRead),
        .iMemWrite     (iMemWrite),
        .iMemWriteData (iMemWriteData),
        .oMemReadData  (oMemReadData),
        .oInterrupt    (oInterrupt),
        .oLed          (oLed),
        .iSwitch       (iSwitch),
        .oDigi         (oDigi),
        .oTxData       (oTxData),
        .oTxStart      (oTxStart),
        .iTxBusy       (iTxBusy),
        .iRxData       (iRxData),
        .iRxValid      (iRxValid)
    );

    // Clock: period 100 so many combinational reads fit inside one cycle
    always #50 clk = ~clk;

    // Count start pulses, sampled away from the active edge
    always @(negedge clk) if (oTxStart === 1'b1) tx_pulses++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Combinational read of one address, compared on the spot
    task automatic check_rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
        iMemAddr = addr;
        #1;
        check(name, oMemReadData, exp);
    endtask

    // One-cycle write; returns 1 time unit after the edge that took it
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        iMemAddr      = addr;
        iMemWriteData = data;
        iMemWrite     = 1'b1;
        @(posedge clk); #1;
        iMemWrite     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic rx_pulse(input logic [7:0] data, input logic with_read);
        @(posedge clk); #1;
        iRxData  = data;
        iRxValid = 1'b1;
        iMemAddr = A_RXD;
        iMemRead = with_read;
        @(posedge clk); #1;
        iRxValid = 1'b0;
        iMemRead = 1'b0;
    endtask

    initial begin
        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        check_rd("rst_th",   A_TH,   32'h0);
        check_rd("rst_tl",   A_TL,   32'h0);
        check_rd("rst_tcon", A_TCON, 32'h0);
        check_rd("rst_led",  A_LED,  32'h0);
        check_rd("rst_digi", A_DIGI, 32'h0);
        check_rd("rst_rxd",  A_RXD,  32'h0);
        check_rd("rst_ucon", A_UCON, 32'h0);
        check("rst_int",   {31'd0, oInterrupt}, 32'h0);
        check("rst_txd",   {24'd0, oTxData},    32'h0);
        check("rst_start", {31'd0, oTxStart},   32'h0);

        // ---------------- register table ----------------
        iSwitch = 8'h5A;
        vecs[0]  = '{1'b1, A_LED,         32'h0000_00A5, 32'h0000_00A5};
        vecs[1]  = '{1'b1, A_DIGI,        32'hFFFF_FFFF, 32'h0000_0FFF};
        vecs[2]  = '{1'b1, A_DIGI,        32'h0000_03F7, 32'h0000_03F7};
        vecs[3]  = '{1'b0, A_SW,          32'h0,         32'h0000_005A};
        vecs[4]  = '{1'b1, A_SW,          32'h1234_5678, 32'h0000_005A};
        vecs[5]  = '{1'b0, 32'h4000_0044, 32'h0,         32'h0};
        vecs[6]  = '{1'b1, 32'h4000_0044, 32'hDEAD_BEEF, 32'h0};
        vecs[7]  = '{1'b0, A_TXD,         32'h0,         32'h0};
        vecs[8]  = '{1'b0, 32'h4000_000F, 32'h0,         32'h0000_00A5};
        vecs[9]  = '{1'b1, A_TH,          32'h1234_5678, 32'h1234_5678};
        vecs[10] = '{1'b0, 32'h0000_0010, 32'h0,         32'h0};
        vecs[11] = '{1'b1, 32'h4000_0016, 32'h0000_03F7, 32'h0000_03F7};
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
            check_rd($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        end
        check("gpio_led",  {24'd0, oLed},  32'h0000_00A5);
        check("gpio_digi", {20'd0, oDigi}, 32'h0000_03F7);

        // ---------------- timer reload ----------------
        bus_write(A_TH, 32'hFFFF_FFFC);
        bus_write(A_TL, 32'hFFFF_FFFE);
        bus_write(A_TCON, 32'h3);
        check_rd("ra_tl0", A_TL, 32'hFFFF_FFFE);
        check_rd("ra_tcon0", A_TCON, 32'h3);
        tick();
        check_rd("ra_tl1", A_TL, 32'hFFFF_FFFF);
        check("ra_int1", {31'd0, oInterrupt}, 32'h0);
        tick();
        check_rd("ra_tl2", A_TL, 32'hFFFF_FFFC);
        check_rd("ra_tcon2", A_TCON, 32'h7);
        check("ra_int2", {31'd0, oInterrupt}, 32'h1);
        bus_write(A_TCON, 32'h0);
        check_rd("ra_tcon3", A_TCON, 32'h0);
        check("ra_int3", {31'd0, oInterrupt}, 32'h0);

        // ---------------- interrupt collision ----------------
        bus_write(A_TL, 32'hFFFF_FFFE);
        bus_write(A_TCON, 32'h3);
        bus_write(A_TCON, 32'h3);   // lands in the overflow cycle
        check_rd("col_tcon", A_TCON, 32'h7);
        check_rd("col_tl", A_TL, 32'hFFFF_FFFC);
        check("col_int", {31'd0, oInterrupt}, 32'h1);
        bus_write(A_TCON, 32'h3);
        check_rd("col_clr_tcon", A_TCON, 32'h3);
        check("col_clr_int", {31'd0, oInterrupt}, 32'h0);
        bus_write(A_TCON, 32'h0);   // also lands in an overflow cycle
        check_rd("col2_tcon", A_TCON, 32'h4);
        check_rd("col2_tl", A_TL, 32'hFFFF_FFFC);
        check("col2_int", {31'd0, oInterrupt}, 32'h0);
        bus_write(A_TCON, 32'h0);
        check_rd("col2_tcon_clr", A_TCON, 32'h0);

        // ---------------- TL write wins, reload without IE ----------------
        bus_write(A_TCON, 32'h1);
        bus_write(A_TL, 32'h0000_0010);
        check_rd("tlw_0", A_TL, 32'h0000_0010);
        tick();
        check_rd("tlw_1", A_TL, 32'h0000_0011);
        bus_write(A_TL, 32'hFFFF_FFFF);
        tick();
        check_rd("noie_tl", A_TL, 32'hFFFF_FFFC);
        check_rd("noie_tcon", A_TCON, 32'h1);
        bus_write(A_TCON, 32'h0);

        // ---------------- UART TX ----------------
        iTxBusy = 1'b0;
        p0 = tx_pulses;
        bus_write(A_TXD, 32'h0000_0041);
        check("tx_start", {31'd0, oTxStart}, 32'h1);
        check("tx_data", {24'd0, oTxData}, 32'h41);
        check_rd("tx_ucon_busy", A_UCON, 32'h1);
        tick();
        check("tx_start_end", {31'd0, oTxStart}, 32'h0);
        check("tx_one_pulse", tx_pulses - p0, 32'd1);
        bus_write(A_TXD, 32'h0000_0042);   // in flight, UART not yet busy
        check("tx_drop1_start", {31'd0, oTxStart}, 32'h0);
        check("tx_drop1_data", {24'd0, oTxData}, 32'h41);
        check_rd("tx_drop1_ucon", A_UCON, 32'h3);
        bus_write(A_UCON, 32'h0);
        check_rd("tx_ucon_clr", A_UCON, 32'h1);
        iTxBusy = 1'b1;
        bus_write(A_TXD, 32'h0000_0043);
        check_rd("tx_drop2_ucon", A_UCON, 32'h3);
        check("tx_drop2_data", {24'd0, oTxData}, 32'h41);
        iTxBusy = 1'b0;
        tick();
        check_rd("tx_idle_ucon", A_UCON, 32'h2);
        check("tx_no_extra", tx_pulses - p0, 32'd1);
        bus_write(A_UCON, 32'h5);
        check_rd("tx_ucon_zero", A_UCON, 32'h0);
        bus_write(A_TXD, 32'h0000_0044);
        check("tx2_start", {31'd0, oTxStart}, 32'h1);
        check("tx2_data", {24'd0, oTxData}, 32'h44);
        iTxBusy = 1'b1;
        tick();
        iTxBusy = 1'b0;
        tick();
        check("tx2_pulses", tx_pulses - p0, 32'd2);
        check_rd("tx2_ucon", A_UCON, 32'h0);

        // ---------------- UART RX ----------------
        rx_pulse(8'h55, 1'b0);
        check_rd("rx1_rxd", A_RXD, 32'h55);
        check_rd("rx1_ucon", A_UCON, 32'h4);
        rx_pulse(8'h66, 1'b0);
        check_rd("rx2_rxd", A_RXD, 32'h66);
        check_rd("rx2_ucon", A_UCON, 32'hC);
        iMemAddr = A_RXD;
        iMemRead = 1'b1;
        #1 check("rx_read", oMemReadData, 32'h66);
        tick();
        iMemRead = 1'b0;
        check_rd("rx_read_ucon", A_UCON, 32'h8);
        bus_write(A_UCON, 32'h0);
        check_rd("rx_ucon_clr", A_UCON, 32'h0);
        rx_pulse(8'h77, 1'b1);
        check_rd("rx_col1_rxd", A_RXD, 32'h77);
        check_rd("rx_col1_ucon", A_UCON, 32'h4);
        rx_pulse(8'h88, 1'b1);
        check_rd("rx_col2_rxd", A_RXD, 32'h88);
        check_rd("rx_col2_ucon", A_UCON, 32'hC);

        // ---------------- async reset mid-count with start pending ----------------
        bus_write(A_TH, 32'h0);
        bus_write(A_TL, 32'hFFFF_FFFF);
        bus_write(A_TCON, 32'h3);
        tick();
        check("pre_rst_int", {31'd0, oInterrupt}, 32'h1);
        p0 = tx_pulses;
        @(posedge clk); #1;
        iMemAddr      = A_TXD;
        iMemWriteData = 32'h99;
        iMemWrite     = 1'b1;
        #3 reset = 1'b0;
        #1;
        check("ar_start", {31'd0, oTxStart},   32'h0);
        check("ar_txd",   {24'd0, oTxData},    32'h0);
        check("ar_led",   {24'd0, oLed},       32'h0);
        check("ar_digi",  {20'd0, oDigi},      32'h0);
        check("ar_int",   {31'd0, oInterrupt}, 32'h0);
        iMemWrite = 1'b0;
        check_rd("ar_tl", A_TL, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) tick();
        check("ar_no_pulse", tx_pulses - p0, 32'd0);
        check_rd("ar_tl_after", A_TL, 32'h0);
        check_rd("ar_tcon_after", A_TCON, 32'h0);
        check_rd("ar_ucon_after", A_UCON, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
